// File: rtl/cmp3_pkg.sv
// Shared types and constants for the 3-input compare-block exerciser/checker.
package cmp3_pkg;

  localparam int unsigned CODE_W    = 3;
  localparam int unsigned NUM_CODES = 8;
  localparam int unsigned DWELL_W   = 8;
  localparam int unsigned ERR_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Stimulus codes {x,y,z} in Gray order: one input toggles per step
  localparam logic [CODE_W-1:0] GRAY3 [NUM_CODES] = '{
    3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100
  };

  // Bit i is the expected o for code i; default models an all-equal detector
  localparam logic [NUM_CODES-1:0] EXPECT_TT_DEFAULT = 8'b1000_0001;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level, cleared by rst_n.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/compare3_vector_checker.sv
// In-hardware self-test for a 3-input combinational compare block: drives all
// eight codes in Gray order, samples the response and reports mismatches.
module compare3_vector_checker
  import cmp3_pkg::*;
#(
  parameter logic [NUM_CODES-1:0] EXPECT_TT = EXPECT_TT_DEFAULT,
  parameter int unsigned          DWELL     = 8,
  parameter int unsigned          SETTLE    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              x,
  output logic              y,
  output logic              z,
  input  logic              o_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic              fail_valid,
  output logic [CODE_W-1:0] fail_code
);

  localparam logic [DWELL_W-1:0] SAMPLE_AT = DWELL_W'(SETTLE - 1);
  localparam logic [DWELL_W-1:0] LAST_AT   = DWELL_W'(DWELL - 1);
  localparam logic [CODE_W-1:0]  LAST_IDX  = CODE_W'(NUM_CODES - 1);

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                busy_d, done_d, pass_d, fail_valid_d;
  logic [ERR_W-1:0]    err_d;
  logic [CODE_W-1:0]   fail_code_d;
  logic                o_sync;

  sync2 u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (o_in),
    .q     (o_sync)
  );

  assign {x, y, z} = code_q;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      dwell_q    <= '0;
      code_q     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_code  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dwell_q    <= dwell_d;
      code_q     <= code_d;
      busy       <= busy_d;
      done       <= done_d;
      pass       <= pass_d;
      err_count  <= err_d;
      fail_valid <= fail_valid_d;
      fail_code  <= fail_code_d;
    end
  end

  // Sequencing, sampling and result bookkeeping
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    dwell_d      = dwell_q;
    code_d       = code_q;
    busy_d       = busy;
    done_d       = done;
    pass_d       = pass;
    err_d        = err_count;
    fail_valid_d = fail_valid;
    fail_code_d  = fail_code;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = RUN;
          idx_d        = '0;
          dwell_d      = '0;
          code_d       = GRAY3[0];
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_code_d  = '0;
        end
      end

      RUN: begin
        dwell_d = dwell_q + DWELL_W'(1);

        if (dwell_q == SAMPLE_AT && o_sync != EXPECT_TT[code_q]) begin
          err_d = err_count + ERR_W'(1);
          if (!fail_valid) begin
            fail_valid_d = 1'b1;
            fail_code_d  = code_q;
          end
        end

        // Sample above is folded into err_d so a last-code miss still clears pass
        if (dwell_q == LAST_AT) begin
          dwell_d = '0;
          if (idx_q != LAST_IDX) begin
            idx_d  = idx_q + CODE_W'(1);
            code_d = GRAY3[idx_q + CODE_W'(1)];
          end else begin
            state_d = DONE;
            idx_d   = '0;
            code_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
